// File: rtl/spi_slave_serdes.sv
// SPI responder serdes: oversamples SCK/SSn/MOSI on Bus_CLK_i, shifts MOSI into a byte
// register and MISO out of a TX shift register fed by a one-byte holding register.
module spi_slave_serdes #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Bus_CLK_i,
    input  logic       RST_i,
    input  logic       RST_SYNC_i,
    input  logic       SPE_i,
    input  logic       CPOL_i,
    input  logic       CPHA_i,
    input  logic       LSBFE_i,
    input  logic [2:0] SPI_Bit_Ctrl_i,
    input  logic       SCK_i,
    input  logic       SSn_i,
    input  logic       MOSI_i,
    output logic       MISO_o,
    output logic       MISO_OEn_o,
    input  logic [7:0] Tx_Data_i,
    input  logic       Tx_Valid_i,
    output logic       Tx_Ready_o,
    output logic [7:0] Rx_Data_o,
    output logic       Rx_Valid_o,
    input  logic       Rx_Ack_i,
    output logic       Rx_Overrun_o,
    output logic       Tx_Underrun_o,
    output logic       Busy_o,
    output logic       Frame_End_o
);
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic {IDLE, ACTIVE} state_t;

    // SCK is synchronized relative to CPOL, so 0 is always the idle level and a
    // rising edge of the synced value is always the leading edge.
    logic [STAGES-1:0] sck_sync, ssn_sync, mosi_sync;
    logic              sck_prev, ssn_prev;

    always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
        if (RST_i) begin
            sck_sync  <= '0;
            ssn_sync  <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            ssn_prev  <= 1'b1;
        end else if (RST_SYNC_i) begin
            sck_sync  <= '0;
            ssn_sync  <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            ssn_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[STAGES-2:0], SCK_i ^ CPOL_i};
            ssn_sync  <= {ssn_sync[STAGES-2:0], SSn_i};
            mosi_sync <= {mosi_sync[STAGES-2:0], MOSI_i};
            sck_prev  <= sck_sync[STAGES-1];
            ssn_prev  <= ssn_sync[STAGES-1];
        end
    end

    logic sck_s, ssn_s, mosi_s;
    logic lead_edge, trail_edge, sample_edge, drive_edge, ssn_fall, ssn_rise;

    assign sck_s       = sck_sync[STAGES-1];
    assign ssn_s       = ssn_sync[STAGES-1];
    assign mosi_s      = mosi_sync[STAGES-1];
    assign lead_edge   = sck_s & ~sck_prev;
    assign trail_edge  = ~sck_s & sck_prev;
    assign sample_edge = CPHA_i ? trail_edge : lead_edge;
    assign drive_edge  = CPHA_i ? lead_edge : trail_edge;
    assign ssn_fall    = ~ssn_s & ssn_prev;
    assign ssn_rise    = ssn_s & ~ssn_prev;

    state_t     state;
    logic [7:0] tx_hold, tx_shift, rx_shift;
    logic [2:0] bit_cnt;
    logic       skip_first, load_pending;

    logic       start, in_frame, do_sample, do_load, done;
    logic [7:0] rx_next, load_val;

    assign start     = (state == IDLE) & SPE_i & ssn_fall;
    assign in_frame  = (state == ACTIVE) & SPE_i & ~ssn_rise;
    assign do_sample = in_frame & sample_edge;
    assign do_load   = start | (in_frame & drive_edge & ~skip_first & load_pending);
    assign done      = do_sample & (bit_cnt == SPI_Bit_Ctrl_i);
    assign rx_next   = LSBFE_i ? {mosi_s, rx_shift[7:1]} : {rx_shift[6:0], mosi_s};
    // An empty holding register shifts out all ones.
    assign load_val  = Tx_Ready_o ? 8'hFF : tx_hold;

    assign MISO_o = (state == ACTIVE) ? (LSBFE_i ? tx_shift[0] : tx_shift[7]) : 1'b1;

    always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state         <= IDLE;
            tx_hold       <= 8'h00;
            tx_shift      <= 8'h00;
            rx_shift      <= 8'h00;
            bit_cnt       <= 3'd0;
            skip_first    <= 1'b0;
            load_pending  <= 1'b0;
            MISO_OEn_o    <= 1'b1;
            Tx_Ready_o    <= 1'b1;
            Rx_Data_o     <= 8'h00;
            Rx_Valid_o    <= 1'b0;
            Rx_Overrun_o  <= 1'b0;
            Tx_Underrun_o <= 1'b0;
            Busy_o        <= 1'b0;
            Frame_End_o   <= 1'b0;
        end else if (RST_SYNC_i) begin
            state         <= IDLE;
            tx_hold       <= 8'h00;
            tx_shift      <= 8'h00;
            rx_shift      <= 8'h00;
            bit_cnt       <= 3'd0;
            skip_first    <= 1'b0;
            load_pending  <= 1'b0;
            MISO_OEn_o    <= 1'b1;
            Tx_Ready_o    <= 1'b1;
            Rx_Data_o     <= 8'h00;
            Rx_Valid_o    <= 1'b0;
            Rx_Overrun_o  <= 1'b0;
            Tx_Underrun_o <= 1'b0;
            Busy_o        <= 1'b0;
            Frame_End_o   <= 1'b0;
        end else begin
            Rx_Overrun_o  <= 1'b0;
            Frame_End_o   <= 1'b0;
            Tx_Underrun_o <= do_load & Tx_Ready_o;

            // A write only lands when empty, so a coincident load sees 0xFF and the write survives.
            if (Tx_Valid_i && Tx_Ready_o) begin
                tx_hold    <= Tx_Data_i;
                Tx_Ready_o <= 1'b0;
            end else if (do_load) begin
                Tx_Ready_o <= 1'b1;
            end

            if (done) begin
                Rx_Data_o    <= rx_next;
                Rx_Valid_o   <= 1'b1;
                Rx_Overrun_o <= Rx_Valid_o & ~Rx_Ack_i;
            end else if (Rx_Ack_i) begin
                Rx_Valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= ACTIVE;
                        tx_shift     <= load_val;
                        rx_shift     <= 8'h00;
                        bit_cnt      <= 3'd0;
                        skip_first   <= CPHA_i;
                        load_pending <= 1'b0;
                        MISO_OEn_o   <= 1'b0;
                        Busy_o       <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!SPE_i || ssn_rise) begin
                        state       <= IDLE;
                        Frame_End_o <= SPE_i;
                        MISO_OEn_o  <= 1'b1;
                        Busy_o      <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (done) begin
                            bit_cnt      <= 3'd0;
                            load_pending <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else if (drive_edge) begin
                        if (skip_first) begin
                            skip_first <= 1'b0;
                        end else if (load_pending) begin
                            tx_shift     <= load_val;
                            load_pending <= 1'b0;
                            rx_shift     <= 8'h00;
                        end else begin
                            tx_shift <= LSBFE_i ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_serdes.sv
// Bench for spi_slave_serdes: a bit-banged SPI master plus a byte-level model of the
// holding register, RX register and pulse counts.
module tb_spi_slave_serdes;
    localparam int SYNC = 2;

    logic       clk = 0, rst = 1, rst_sync = 0, spe = 1, cpol = 0, cpha = 0, lsbfe = 0;
    logic [2:0] bctl = 3'd7;
    logic       sck = 0, ssn = 1, mosi = 0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 0, rx_ack = 0;
    logic       miso, miso_oen, tx_ready, rx_valid, rx_ovr, tx_und, busy, fe;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    spi_slave_serdes #(.SYNC_STAGES(SYNC)) dut (
        .Bus_CLK_i(clk), .RST_i(rst), .RST_SYNC_i(rst_sync), .SPE_i(spe),
        .CPOL_i(cpol), .CPHA_i(cpha), .LSBFE_i(lsbfe), .SPI_Bit_Ctrl_i(bctl),
        .SCK_i(sck), .SSn_i(ssn), .MOSI_i(mosi), .MISO_o(miso), .MISO_OEn_o(miso_oen),
        .Tx_Data_i(tx_data), .Tx_Valid_i(tx_valid), .Tx_Ready_o(tx_ready),
        .Rx_Data_o(rx_data), .Rx_Valid_o(rx_valid), .Rx_Ack_i(rx_ack),
        .Rx_Overrun_o(rx_ovr), .Tx_Underrun_o(tx_und), .Busy_o(busy), .Frame_End_o(fe)
    );

    int errs = 0, checks = 0;
    // model state
    logic       exp_full = 0, exp_valid = 0, chk_rx = 1;
    logic [7:0] exp_hold = 0, exp_data = 0;
    int         exp_under = 0, exp_ovr = 0, exp_fe = 0;
    int         n_under = 0, n_ovr = 0, n_fe = 0;
    int         ack_mode = 0;
    logic [7:0] m_tx[4], s_tx[4], cap_log[4], rx_log[4];
    logic       s_wr[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic prev_ovr = 0, prev_und = 0, prev_fe = 0;
    always @(negedge clk) begin
        if (!rst && !rst_sync) begin
            if (rx_ovr) n_ovr++;
            if (tx_und) n_under++;
            if (fe) n_fe++;
            chk("oen_vs_busy", miso_oen, !busy);
            if (!busy) chk("idle_miso", miso, 1);
            chk("pulse_width", (rx_ovr & prev_ovr) | (tx_und & prev_und) | (fe & prev_fe), 0);
            if (chk_rx) begin
                chk("rx_valid", rx_valid, exp_valid);
                chk("rx_data", rx_data, exp_data);
            end
        end
        prev_ovr = rx_ovr;
        prev_und = tx_und;
        prev_fe  = fe;
    end

    task automatic write_tx(input logic [7:0] d);
        int w = 0;
        while (!tx_ready && w < 50) begin cyc(1); w++; end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data = d; tx_valid = 1; cyc(1); tx_valid = 0;
        chk("tx_ready_drop", tx_ready, 0);
        exp_full = 1; exp_hold = d;
    endtask

    task automatic model_load(output logic [7:0] v);
        v = exp_full ? exp_hold : 8'hFF;
        if (!exp_full) exp_under++;
        exp_full = 0;
    endtask

    task automatic ack_now();
        if (exp_valid) begin
            rx_ack = 1; cyc(1); rx_ack = 0; exp_valid = 0;
        end
    endtask

    task automatic byte_done(input int i, input logic [7:0] cap, input logic [7:0] cur);
        int k; logic [7:0] mask, mm, ecap;
        k = int'(bctl);
        mask = 8'((1 << (k + 1)) - 1);
        ecap = lsbfe ? (cur & mask) : (cur >> (7 - k));
        chk("miso_byte", cap, ecap);
        cap_log[i] = cap;
        mm = m_tx[i] & mask;
        if (exp_valid) exp_ovr++;
        exp_valid = 1;
        exp_data = lsbfe ? 8'(mm << (7 - k)) : mm;
        rx_log[i] = rx_data;
        chk("rx_byte", rx_data, exp_data);
        chk("rx_valid_byte", rx_valid, 1);
        chk_rx = 1;
        if (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 1) == 1)) ack_now();
    endtask

    task automatic frame(input int nb, input int abort_at);
        int h, k, nbits; logic [7:0] cur, cap; logic b, stop;
        h = $urandom_range(4, 7); k = int'(bctl); nbits = 0; stop = 0;
        ssn = 0; model_load(cur); cyc(h + SYNC);
        chk("busy_start", busy, 1);
        chk("oen_start", miso_oen, 0);
        chk("tx_ready_start", tx_ready, 1);
        for (int i = 0; i < nb && !stop; i++) begin
            if (i > 0 && cpha) model_load(cur);
            cap = 0;
            for (int j = 0; j <= k && !stop; j++) begin
                if (nbits == abort_at) stop = 1;
                else begin
                    b = lsbfe ? m_tx[i][j] : m_tx[i][k-j];
                    if (j == k) chk_rx = 0;
                    if (!cpha) begin
                        mosi = b; cyc(h);
                        if (lsbfe) cap[j] = miso; else cap = {cap[6:0], miso};
                        sck = !cpol; cyc(h); sck = cpol;
                    end else begin
                        sck = !cpol; mosi = b; cyc(h);
                        if (lsbfe) cap[j] = miso; else cap = {cap[6:0], miso};
                        sck = cpol; cyc(h);
                    end
                    nbits++;
                    if (j == 0 && i + 1 < nb && s_wr[i+1]) write_tx(s_tx[i+1]);
                    if (j == k) begin
                        byte_done(i, cap, cur);
                        if (!cpha) model_load(cur);
                    end
                end
            end
        end
        cyc(h); ssn = 1; exp_fe++; mosi = 0;
        cyc(SYNC + 3);
        chk("busy_end", busy, 0);
        chk("oen_end", miso_oen, 1);
        chk("underrun_cnt", n_under, exp_under);
        chk("overrun_cnt", n_ovr, exp_ovr);
        chk("frame_end_cnt", n_fe, exp_fe);
    endtask

    task automatic cfg(input logic pol, input logic pha, input logic lsb, input logic [2:0] bc);
        cpol = pol; cpha = pha; lsbfe = lsb; bctl = bc; sck = pol;
        s_wr = '{default: 0};
        cyc(4);
    endtask

    initial begin
        int u0, o0, f0;
        cyc(3);
        chk("rst_miso", miso, 1);
        chk("rst_oen", miso_oen, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_pulses", {rx_ovr, tx_und, fe}, 0);
        chk("rst_busy", busy, 0);
        rst = 0; cyc(4);

        // mode 0, MSB-first, 0xA5 out, 0x3C in
        cfg(0, 0, 0, 7); ack_mode = 0;
        m_tx[0] = 8'h3C; write_tx(8'hA5);
        frame(1, -1);
        chk("t1_miso", cap_log[0], 8'hA5);
        chk("t1_rx", rx_data, 8'h3C);
        chk("t1_rx_valid", rx_valid, 1);
        ack_now();

        // mode 3, LSB-first, back-to-back bytes
        cfg(1, 1, 1, 7); ack_mode = 1;
        m_tx[0] = 8'h81; m_tx[1] = 8'h7E; s_wr[1] = 1; s_tx[1] = 8'h34;
        write_tx(8'h12); u0 = n_under;
        frame(2, -1);
        chk("t2_rx0", rx_log[0], 8'h81);
        chk("t2_rx1", rx_log[1], 8'h7E);
        chk("t2_miso0", cap_log[0], 8'h12);
        chk("t2_miso1", cap_log[1], 8'h34);
        chk("t2_no_underrun", n_under - u0, 0);

        // modes 1 and 2, 4-bit frames
        cfg(0, 1, 0, 3); m_tx[0] = 8'h0B; frame(1, -1);
        chk("t3_mode1_rx", rx_log[0], 8'h0B);
        cfg(1, 0, 0, 3); m_tx[0] = 8'h0B; frame(1, -1);
        chk("t3_mode2_rx", rx_log[0], 8'h0B);

        // overrun
        cfg(0, 0, 0, 7); ack_mode = 0; ack_now();
        m_tx[0] = 8'hC3; m_tx[1] = 8'h96; o0 = n_ovr;
        frame(2, -1);
        chk("t4_overrun", n_ovr - o0, 1);
        chk("t4_rx", rx_data, 8'h96);
        ack_now();

        // underrun
        cfg(0, 1, 0, 7); ack_mode = 1; m_tx[0] = 8'h5A; u0 = n_under;
        frame(1, -1);
        chk("t5_miso_ff", cap_log[0], 8'hFF);
        chk("t5_underrun", n_under - u0, 1);

        // aborted frame then clean frame
        cfg(0, 0, 0, 7); ack_mode = 0; m_tx[0] = 8'hE7; write_tx(8'h77); f0 = n_fe;
        frame(1, 5);
        chk("t6_frame_end", n_fe - f0, 1);
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_oen", miso_oen, 1);
        m_tx[0] = 8'h55; frame(1, -1);
        chk("t6_clean_rx", rx_log[0], 8'h55);
        ack_now();

        // SPE low: SSn ignored, then mid-frame drop without frame_end
        spe = 0; ssn = 0; cyc(8);
        chk("spe_ignore", busy, 0);
        ssn = 1; cyc(5); spe = 1; cyc(2);
        f0 = n_fe;
        begin
            logic [7:0] tmp;
            ssn = 0; model_load(tmp); cyc(6);
            chk("spe_busy", busy, 1);
            spe = 0; cyc(2);
            chk("spe_drop", busy, 0);
            ssn = 1; cyc(5); spe = 1; cyc(2);
            chk("spe_no_fe", n_fe - f0, 0);
        end

        // random frames
        for (int r = 0; r < 25; r++) begin
            int nb;
            cfg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd7);
            ack_mode = 2; nb = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                m_tx[i] = 8'($urandom); s_tx[i] = 8'($urandom); s_wr[i] = 1'($urandom_range(0, 3) != 0);
            end
            if (s_wr[0]) write_tx(s_tx[0]);
            frame(nb, -1);
        end

        // synchronous clear
        write_tx(8'h11);
        rst_sync = 1; cyc(1); rst_sync = 0;
        exp_full = 0; exp_valid = 0; exp_data = 0;
        chk("sync_clr_tx_ready", tx_ready, 1);
        chk("sync_clr_rx", {rx_valid, rx_data}, 0);

        // async reset mid-frame
        cfg(0, 0, 0, 7); ack_mode = 0;
        m_tx[0] = 8'hA3; frame(1, -1);
        write_tx(8'h5A);
        ssn = 0; cyc(6); sck = 1; cyc(5);
        @(posedge clk); #2 rst = 1; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_oen", miso_oen, 1);
        chk("mid_rst_miso", miso, 1);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_rx", {rx_valid, rx_data}, 0);
        exp_full = 0; exp_valid = 0; exp_data = 0;
        sck = 0; ssn = 1; cyc(3); rst = 0; cyc(4);
        m_tx[0] = 8'h3C; write_tx(8'h96);
        frame(1, -1);
        chk("post_rst_miso", cap_log[0], 8'h96);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
